// File: rtl/spi_controller.sv
// spi_controller: write-only SPI mode-0 master sending 16-bit {1, addr[6:0], data[7:0]} frames
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] in_addr,
    input  logic [7:0] in_data,
    output logic       busy,
    output logic       done,
    output logic       nCS,
    output logic       SCLK,
    output logic       COPI
);
    typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;

    state_t      r_state;
    logic [7:0]  r_phase;
    logic [4:0]  r_bits;
    logic [15:0] r_shift;
    logic        r_ncs;
    logic        r_sclk;
    logic        r_copi;
    logic        r_busy;
    logic        r_done;
    logic        r_ready;

    logic w_accept;
    logic w_phase_end;

    assign w_accept    = in_valid && r_ready;
    assign w_phase_end = r_phase == 8'(CLK_DIV - 1);

    assign in_ready = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign nCS      = r_ncs;
    assign SCLK     = r_sclk;
    assign COPI     = r_copi;

    // Frame sequencer: the first LOW phase is also nCS setup, HOLD is nCS hold, GAP forces an nCS high time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_bits  <= '0;
            r_shift <= '0;
            r_ncs   <= 1'b1;
            r_sclk  <= 1'b0;
            r_copi  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (w_accept) begin
                    r_state <= LOW;
                    r_shift <= {1'b1, in_addr, in_data};
                    r_phase <= '0;
                    r_bits  <= '0;
                    r_ncs   <= 1'b0;
                    r_sclk  <= 1'b0;
                    r_copi  <= 1'b1;
                    r_busy  <= 1'b1;
                    r_ready <= 1'b0;
                end else begin
                    r_ready <= 1'b1;
                end
            end else if (!w_phase_end) begin
                r_phase <= r_phase + 8'd1;
            end else begin
                r_phase <= '0;
                case (r_state)
                    LOW: begin
                        r_state <= HIGH;
                        r_sclk  <= 1'b1;
                    end
                    HIGH: begin
                        r_sclk <= 1'b0;
                        r_bits <= r_bits + 5'd1;
                        if (r_bits == 5'd15) begin
                            r_state <= HOLD;
                            r_copi  <= 1'b0;
                        end else begin
                            r_state <= LOW;
                            r_shift <= {r_shift[14:0], 1'b0};
                            r_copi  <= r_shift[14];
                        end
                    end
                    HOLD: begin
                        r_state <= GAP;
                        r_ncs   <= 1'b1;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 SHALL have parameter: CLK_DIV, default 4, SCLK half-period in clk cycles; legal range 3..255.
REQ-002 SHALL have ports, in this order:
  clk  input  1  system clock; all logic on rising edge.
  rst  input  1  reset, asynchronous, active-high.
  in_valid  input  1  write request valid.
  in_ready  output  1  controller can accept a request.
  in_addr  input  7  target register address.
  in_data  input  8  write data.
  busy  output  1  transaction in progress.
  done  output  1  one-cycle pulse at transaction completion.
  nCS  output  1  active-low chip select.
  SCLK  output  1  SPI clock, idles low.
  COPI  output  1  serial data to peripheral.
REQ-003 SHALL be the one clock domain and the one reset named in REQ-002; no other clocks or resets.

Function
REQ-004 SHALL send write-only frames, 16 bits, MSB first: bit15=1 (write), bits14:8=in_addr, bits7:0=in_data.
REQ-005 SHALL use SPI mode 0: COPI changes only while SCLK low; peripheral samples on SCLK rising edge.
REQ-006 SHALL drive in_ready=1 only in IDLE; a request is accepted on a clk edge where in_valid && in_ready.
REQ-007 SHALL latch in_addr/in_data into a 16-bit shift register on acceptance; later input changes have no effect on the frame.
REQ-008 SHALL ignore in_valid while busy; no queuing.
REQ-009 SHALL implement FSM states IDLE, LOW, HIGH, HOLD, GAP; each non-IDLE phase lasts exactly CLK_DIV clk cycles.
REQ-010 IDLE -> LOW on acceptance; in the first cycle after acceptance nCS=0, SCLK=0, COPI=frame bit15, busy=1.
REQ-011 LOW -> HIGH after CLK_DIV cycles; SCLK=1 throughout HIGH; COPI held stable.
REQ-012 HIGH -> LOW (next bit, shift register advanced, COPI = next bit) while bits remain; after the 16th HIGH -> HOLD.
REQ-013 HOLD: nCS=0, SCLK=0, COPI=0; the first LOW phase doubles as nCS setup, HOLD as nCS hold.
REQ-014 GAP: nCS=1, SCLK=0, COPI=0; guarantees the peripheral sees an nCS rising edge before any new frame.
REQ-015 GAP -> IDLE; done=1 for exactly the first IDLE cycle, busy=0 and in_ready=1 in that same cycle.
REQ-016 SHALL keep busy high for exactly 34*CLK_DIV cycles per transaction; nCS low for exactly 33*CLK_DIV cycles; exactly 16 SCLK rising edges.
REQ-017 SHALL use a bit counter of 5 bits (0..16) and a phase counter of 8 bits; neither wraps within a transaction.
REQ-018 A request presented in the done cycle SHALL be accepted in that cycle; the next frame starts the following cycle, giving a total nCS-high gap of CLK_DIV+1 cycles.
REQ-019 Outputs SHALL be registered; no combinational path from inputs to nCS/SCLK/COPI.

Reset
REQ-020 While rst=1: state=IDLE, nCS=1, SCLK=0, COPI=0, busy=0, done=0, in_ready=0, counters and shift register cleared.
REQ-021 in_ready SHALL rise the first cycle after rst deasserts.
REQ-022 rst asserted mid-transaction SHALL abort immediately with REQ-020 values; no done pulse; no partial frame resumes.

Verification
REQ-023 Single write, CLK_DIV=4, addr=0x04, data=0xA5 -> COPI sampled on SCLK rises = 0x84A5; 16 rises; nCS low 132 cycles; busy 136 cycles; one done pulse.
REQ-024 in_valid held high with two words (0x00/0xFF then 0x01/0x3C) -> second accepted in first done cycle; frames 0x80FF then 0x813C; nCS high gap 5 cycles.
REQ-025 in_valid pulsed with addr=0x02 while busy -> ignored; in-flight frame unchanged; no extra done.
REQ-026 rst pulsed after 7th SCLK rise -> nCS=1, SCLK=0, COPI=0 within reset; no done; next request transmits a full correct frame.
REQ-027 Loopback, CLK_DIV=3, with spi_peripheral (rst_n = ~rst) -> write 0x00..0x04 with 0x11,0x22,0x33,0x44,0x80 -> all five peripheral registers hold those values; write to 0x05 changes none.
REQ-028 in_data changed the cycle after acceptance -> transmitted frame reflects the value at acceptance.
